// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: load-use stall, branch squash,
// data-memory freeze (fixed latency or ready handshake), wait timeout and stall counter.
module hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int MEM_LAT   = 1,
  parameter int USE_READY = 0,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_is_load,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_wr_reg,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             redirect,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             freeze_back,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d, wcnt_inc;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             load_use, freeze;

  always_comb begin
    load_use = ex_is_load & ex_reg_write & (ex_wr_reg != '0) &
               ((id_rs_used & (id_rs == ex_wr_reg)) | (id_rt_used & (id_rt == ex_wr_reg)));
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze        = 1'b0;
    wcnt_inc      = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
    if (USE_READY != 0) begin
      freeze = mem_access & ~mem_ready;
      if (freeze) begin
        state_d = WAIT;
        wcnt_d  = wcnt_inc;
        if (32'(wcnt_inc) >= 32'(TIMEOUT)) mem_timeout_d = 1'b1;
      end else begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    end else begin
      // wcnt holds the remaining frozen cycles after the current one
      case (state_q)
        IDLE: if (mem_access && (MEM_LAT > 1)) begin
          freeze  = 1'b1;
          state_d = WAIT;
          wcnt_d  = 16'(MEM_LAT - 2);
        end
        WAIT: if (wcnt_q != '0) begin
          freeze = 1'b1;
          wcnt_d = wcnt_q - 16'd1;
        end else begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    freeze_back = 1'b0;
    if (!rst) begin
      if (freeze) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        freeze_back = 1'b1;
      end else if (redirect) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (load_use) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (cnt_clr)                             stall_count_d = '0;
    else if (stall_pc && ~&stall_count_q)    stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: a fixed-latency instance (MEM_LAT=4, CNT_W=4) and a handshake
// instance (TIMEOUT=8) share one set of inputs.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ex_is_load, ex_reg_write, id_rs_used, id_rt_used;
  logic       redirect, mem_access, mem_ready, cnt_clr;
  logic [4:0] ex_wr_reg, id_rs, id_rt;

  logic        f_spc, f_sif, f_fif, f_fid, f_frz, f_to;
  logic [3:0]  f_cnt;
  logic        h_spc, h_sif, h_fif, h_fid, h_frz, h_to;
  logic [15:0] h_cnt;
  logic [4:0]  fo, ho;
  assign fo = {f_spc, f_sif, f_fif, f_fid, f_frz};
  assign ho = {h_spc, h_sif, h_fif, h_fid, h_frz};

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_LU   = 5'b11010;
  localparam logic [4:0] O_RD   = 5'b00110;
  localparam logic [4:0] O_FRZ  = 5'b11001;

  hazard_ctrl #(.REG_W(5), .MEM_LAT(4), .USE_READY(0), .TIMEOUT(64), .CNT_W(4)) u_fix (
    .clk(clk), .rst(rst), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .ex_wr_reg(ex_wr_reg), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .redirect(redirect), .mem_access(mem_access),
    .mem_ready(mem_ready), .cnt_clr(cnt_clr), .stall_pc(f_spc), .stall_ifid(f_sif),
    .flush_ifid(f_fif), .flush_idex(f_fid), .freeze_back(f_frz), .mem_timeout(f_to),
    .stall_count(f_cnt));

  hazard_ctrl #(.REG_W(5), .MEM_LAT(1), .USE_READY(1), .TIMEOUT(8), .CNT_W(16)) u_hs (
    .clk(clk), .rst(rst), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .ex_wr_reg(ex_wr_reg), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .redirect(redirect), .mem_access(mem_access),
    .mem_ready(mem_ready), .cnt_clr(cnt_clr), .stall_pc(h_spc), .stall_ifid(h_sif),
    .flush_ifid(h_fif), .flush_idex(h_fid), .freeze_back(h_frz), .mem_timeout(h_to),
    .stall_count(h_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_is_load = 0; ex_reg_write = 0; ex_wr_reg = 0; id_rs = 0; id_rt = 0;
    id_rs_used = 0; id_rt_used = 0; redirect = 0; mem_access = 0; mem_ready = 0;
    cnt_clr = 0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    ex_is_load = 1; ex_reg_write = 1; ex_wr_reg = r; id_rs = r; id_rs_used = 1;
  endtask

  task automatic test_reset();
    rst = 1; set_lu(5'd5); mem_access = 1; redirect = 1;
    #1;
    n_chk++; if (fo !== O_NONE) begin n_fail++; $display("FAIL reset_fix_outs got %b want %b", fo, O_NONE); end
    n_chk++; if (ho !== O_NONE) begin n_fail++; $display("FAIL reset_hs_outs got %b want %b", ho, O_NONE); end
    tick();
    n_chk++; if (f_cnt !== 4'd0 || f_to !== 1'b0) begin n_fail++; $display("FAIL reset_state got cnt=%0d to=%b want 0 0", f_cnt, f_to); end
    n_chk++; if (h_cnt !== 16'd0 || h_to !== 1'b0) begin n_fail++; $display("FAIL reset_hs_state got cnt=%0d to=%b want 0 0", h_cnt, h_to); end
    idle_in(); rst = 0; tick();
  endtask

  task automatic test_load_use();
    set_lu(5'd5); #1;
    n_chk++; if (fo !== O_LU) begin n_fail++; $display("FAIL lu_rs got %b want %b", fo, O_LU); end
    tick(); idle_in(); #1;
    n_chk++; if (f_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_count got %0d want 1", f_cnt); end
    n_chk++; if (fo !== O_NONE) begin n_fail++; $display("FAIL lu_clear got %b want %b", fo, O_NONE); end
    set_lu(5'd0); #1;
    n_chk++; if (fo !== O_NONE) begin n_fail++; $display("FAIL lu_r0 got %b want %b", fo, O_NONE); end
    tick(); idle_in();
    ex_is_load = 1; ex_reg_write = 1; ex_wr_reg = 7; id_rt = 7; id_rt_used = 1; id_rs = 7; #1;
    n_chk++; if (fo !== O_LU) begin n_fail++; $display("FAIL lu_rt got %b want %b", fo, O_LU); end
    tick(); id_rt_used = 0; #1;
    n_chk++; if (fo !== O_NONE) begin n_fail++; $display("FAIL lu_unused got %b want %b", fo, O_NONE); end
    set_lu(5'd9); ex_reg_write = 0; #1;
    n_chk++; if (fo !== O_NONE) begin n_fail++; $display("FAIL lu_nowrite got %b want %b", fo, O_NONE); end
    tick(); idle_in(); #1;
    n_chk++; if (f_cnt !== 4'd2) begin n_fail++; $display("FAIL lu_count2 got %0d want 2", f_cnt); end
  endtask

  task automatic test_redirect();
    set_lu(5'd3); redirect = 1; #1;
    n_chk++; if (fo !== O_RD) begin n_fail++; $display("FAIL redirect_prio got %b want %b", fo, O_RD); end
    tick(); idle_in(); #1;
    n_chk++; if (f_cnt !== 4'd2) begin n_fail++; $display("FAIL redirect_count got %0d want 2", f_cnt); end
  endtask

  task automatic test_fixed_freeze();
    cnt_clr = 1; tick(); idle_in();
    mem_access = 1;
    for (int a = 0; a < 2; a++) begin
      for (int c = 0; c < 3; c++) begin
        #1;
        n_chk++; if (fo !== O_FRZ) begin n_fail++; $display("FAIL fix_frz a%0d c%0d got %b want %b", a, c, fo, O_FRZ); end
        tick();
      end
      #1;
      n_chk++; if (fo !== O_NONE) begin n_fail++; $display("FAIL fix_release a%0d got %b want %b", a, fo, O_NONE); end
      tick();
    end
    idle_in(); #1;
    n_chk++; if (fo !== O_NONE) begin n_fail++; $display("FAIL fix_idle got %b want %b", fo, O_NONE); end
    n_chk++; if (f_cnt !== 4'd6) begin n_fail++; $display("FAIL fix_count got %0d want 6", f_cnt); end
  endtask

  task automatic test_freeze_load_use();
    cnt_clr = 1; tick(); idle_in();
    mem_access = 1; set_lu(5'd4); redirect = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (fo !== O_FRZ) begin n_fail++; $display("FAIL frz_lu c%0d got %b want %b", c, fo, O_FRZ); end
      tick();
    end
    redirect = 0; #1;
    n_chk++; if (fo !== O_LU) begin n_fail++; $display("FAIL frz_lu_bubble got %b want %b", fo, O_LU); end
    tick(); idle_in(); #1;
    n_chk++; if (fo !== O_NONE) begin n_fail++; $display("FAIL frz_lu_after got %b want %b", fo, O_NONE); end
    n_chk++; if (f_cnt !== 4'd4) begin n_fail++; $display("FAIL frz_lu_count got %0d want 4", f_cnt); end
  endtask

  task automatic test_handshake();
    rst = 1; tick(); rst = 0; idle_in();
    mem_access = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++; if (ho !== O_FRZ) begin n_fail++; $display("FAIL hs_frz c%0d got %b want %b", c, ho, O_FRZ); end
      tick();
    end
    mem_ready = 1; #1;
    n_chk++; if (ho !== O_NONE) begin n_fail++; $display("FAIL hs_ready got %b want %b", ho, O_NONE); end
    tick(); #1;
    n_chk++; if (ho !== O_NONE) begin n_fail++; $display("FAIL hs_first_ready got %b want %b", ho, O_NONE); end
    n_chk++; if (h_cnt !== 16'd5 || h_to !== 1'b0) begin n_fail++; $display("FAIL hs_count got cnt=%0d to=%b want 5 0", h_cnt, h_to); end
    tick(); mem_ready = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_chk++; if (h_to !== (i >= 8)) begin n_fail++; $display("FAIL hs_timeout i%0d got %b want %b", i, h_to, (i >= 8)); end
    end
    #1;
    n_chk++; if (ho !== O_FRZ) begin n_fail++; $display("FAIL hs_frz_after_to got %b want %b", ho, O_FRZ); end
    idle_in(); tick(); tick(); #1;
    n_chk++; if (h_to !== 1'b1 || ho !== O_NONE) begin n_fail++; $display("FAIL hs_sticky got to=%b outs=%b want 1 %b", h_to, ho, O_NONE); end
    rst = 1; tick(); rst = 0; #1;
    n_chk++; if (h_to !== 1'b0) begin n_fail++; $display("FAIL hs_to_rst got %b want 0", h_to); end
  endtask

  task automatic test_saturation();
    cnt_clr = 1; tick(); idle_in();
    set_lu(5'd6);
    for (int c = 0; c < 20; c++) tick();
    n_chk++; if (f_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_count got %0d want 15", f_cnt); end
    cnt_clr = 1; tick(); #1;
    n_chk++; if (f_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr got %0d want 0", f_cnt); end
    idle_in();
  endtask

  task automatic test_rst_in_wait();
    mem_access = 1; tick(); #1;
    n_chk++; if (fo !== O_FRZ) begin n_fail++; $display("FAIL rw_wait got %b want %b", fo, O_FRZ); end
    rst = 1; #1;
    n_chk++; if (fo !== O_NONE) begin n_fail++; $display("FAIL rw_during got %b want %b", fo, O_NONE); end
    tick(); rst = 0; mem_access = 0; #1;
    n_chk++; if (fo !== O_NONE || f_cnt !== 4'd0) begin n_fail++; $display("FAIL rw_after got outs=%b cnt=%0d want %b 0", fo, f_cnt, O_NONE); end
    mem_access = 1; #1;
    n_chk++; if (fo !== O_FRZ) begin n_fail++; $display("FAIL rw_restart got %b want %b", fo, O_FRZ); end
    tick(); tick(); tick(); #1;
    n_chk++; if (fo !== O_NONE) begin n_fail++; $display("FAIL rw_restart_end got %b want %b", fo, O_NONE); end
    idle_in(); tick();
  endtask

  initial begin
    idle_in(); rst = 1;
    tick(); tick();
    test_reset();
    test_load_use();
    test_redirect();
    test_fixed_freeze();
    test_freeze_load_use();
    test_handshake();
    test_saturation();
    test_rst_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
